// File: rtl/mem_responder_pkg.sv
// Shared constants and FSM encoding for the memory responder.
// Optional bounds checking is enabled by defining MEM_BOUNDS_EN.
package mem_responder_pkg;

    localparam int          WORD_W          = 32;
    localparam int          DEF_ADDR_BITS   = 9;
    localparam int          DEF_WAIT_STATES = 2;
    localparam logic [31:0] FAULT_DATA      = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Word-wide storage with one synchronous read/write port.
// Contents are never reset; read data is registered and read-first on a write.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 gclk,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge gclk) begin
        if (en) begin
            if (we)
                mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Wait-stated memory responder: IDLE -> WAIT -> ACCESS -> DONE, one Rdy pulse per request.
// Define MEM_BOUNDS_EN to add out-of-range detection and the sticky oMemFault output.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic              iClk,
    input  logic              nRst,
    input  logic [31:0]       iMemAddr,
    input  logic [31:0]       iMemData,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    output logic [31:0]       oMemData,
    output logic              oMemRdy
`ifdef MEM_BOUNDS_EN
   ,output logic              oMemFault
`endif
);

    localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [WORD_W-1:0]     data_q;
    logic                  wr_q;
    logic [WORD_W-1:0]     rd_data;
    logic                  mem_en;
    logic                  mem_we;
    logic                  oob_q;

`ifdef MEM_BOUNDS_EN
    logic oob_now;
    assign oob_now = |iMemAddr[31:ADDR_BITS];
`else
    // Upper address bits are deliberately dropped: the address wraps modulo the depth.
    logic unused_addr_hi;
    assign unused_addr_hi = ^iMemAddr[31:ADDR_BITS];
`endif

    // Array is driven only from ACCESS; an async reset leaves the FSM in IDLE so
    // an in-flight write can never commit.
    assign mem_en = (state == ACCESS);
    assign mem_we = mem_en && wr_q && !oob_q;

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .gclk  (iClk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (rd_data)
    );

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            oob_q    <= 1'b0;
            oMemRdy  <= 1'b0;
            oMemData <= '0;
`ifdef MEM_BOUNDS_EN
            oMemFault <= 1'b0;
`endif
        end else begin
            oMemRdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (iMemRead || iMemWrite) begin
                        addr_q   <= iMemAddr[ADDR_BITS-1:0];
                        data_q   <= iMemData;
                        wr_q     <= iMemWrite;   // write wins when both are high
`ifdef MEM_BOUNDS_EN
                        oob_q    <= oob_now;
`else
                        oob_q    <= 1'b0;
`endif
                        wait_cnt <= '0;
                        state    <= (WAIT_STATES == 0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WS_LAST) begin
                        wait_cnt <= '0;
                        state    <= ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ACCESS: begin
                    state <= DONE;
                end
                DONE: begin
                    // Array read data is valid here; publish it with the Rdy pulse.
                    oMemRdy <= 1'b1;
                    if (!wr_q)
                        oMemData <= oob_q ? FAULT_DATA : rd_data;
`ifdef MEM_BOUNDS_EN
                    if (oob_q)
                        oMemFault <= 1'b1;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (ADDR_BITS=9, WAIT_STATES=2).
// Covers both the default build and the MEM_BOUNDS_EN build.
module tb_mem_responder;

    logic        iClk = 1'b0;
    logic        nRst = 1'b0;
    logic [31:0] iMemAddr = '0;
    logic [31:0] iMemData = '0;
    logic        iMemRead = 1'b0;
    logic        iMemWrite = 1'b0;
    logic [31:0] oMemData;
    logic        oMemRdy;
`ifdef MEM_BOUNDS_EN
    logic        oMemFault;
`endif

    int checks = 0;
    int errors = 0;

    always #5 iClk = ~iClk;

    mem_responder #(.ADDR_BITS(9), .WAIT_STATES(2)) dut (
        .iClk      (iClk),
        .nRst      (nRst),
        .iMemAddr  (iMemAddr),
        .iMemData  (iMemData),
        .iMemRead  (iMemRead),
        .iMemWrite (iMemWrite),
        .oMemData  (oMemData),
        .oMemRdy   (oMemRdy)
`ifdef MEM_BOUNDS_EN
       ,.oMemFault (oMemFault)
`endif
    );

    // Issue one request, drop it during its Rdy cycle, and watch 20 cycles.
    // lat = edges after acceptance edge at which Rdy is first seen (-1 if never).
    task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic rd,
                           input logic wr, output int lat, output logic [31:0] q,
                           output int pulses);
        @(negedge iClk);
        iMemAddr = a; iMemData = d; iMemRead = rd; iMemWrite = wr;
        @(posedge iClk);
        lat = -1; pulses = 0; q = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge iClk);
            @(negedge iClk);
            if (oMemRdy) begin
                if (lat < 0) begin
                    lat = k; q = oMemData;
                    iMemRead = 1'b0; iMemWrite = 1'b0;
                end
                pulses++;
            end
        end
        iMemRead = 1'b0; iMemWrite = 1'b0;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        #2;
        checks++;
        if (oMemRdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %0b want 0", oMemRdy); end
        checks++;
        if (oMemData !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", oMemData); end
`ifdef MEM_BOUNDS_EN
        checks++;
        if (oMemFault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b want 0", oMemFault); end
`endif
        repeat (2) @(negedge iClk);
        nRst = 1'b1;
    endtask

    task automatic test_write();
        int lat, pulses; logic [31:0] q;
        run_req(32'd5, 32'h0000_00AA, 1'b0, 1'b1, lat, q, pulses);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL write_latency got %0d want 4", lat); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL write_pulses got %0d want 1", pulses); end
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL write_data_hold got %h want 0", q); end
    endtask

    task automatic test_read();
        int lat, pulses; logic [31:0] q;
        run_req(32'd5, 32'h0, 1'b1, 1'b0, lat, q, pulses);
        checks++;
        if (lat != 4 || pulses != 1) begin errors++; $display("FAIL read_timing got lat %0d pulses %0d want 4 1", lat, pulses); end
        checks++;
        if (q !== 32'h0000_00AA) begin errors++; $display("FAIL read_data got %h want 000000aa", q); end
        checks++;
        if (oMemData !== 32'h0000_00AA) begin errors++; $display("FAIL read_data_held got %h want 000000aa", oMemData); end
        run_req(32'd6, 32'h0000_0066, 1'b0, 1'b1, lat, q, pulses);
        checks++;
        if (q !== 32'h0000_00AA || oMemData !== 32'h0000_00AA) begin
            errors++; $display("FAIL write_keeps_data got %h/%h want 000000aa", q, oMemData);
        end
    endtask

    task automatic test_back_to_back();
        int lat, pulses; logic [31:0] q;
        int t [2]; logic [31:0] dq [2]; int n = 0;
        run_req(32'd0, 32'h0000_0100, 1'b0, 1'b1, lat, q, pulses);
        run_req(32'd1, 32'h0000_0101, 1'b0, 1'b1, lat, q, pulses);
        @(negedge iClk);
        iMemAddr = 32'd0; iMemRead = 1'b1;
        @(posedge iClk);
        for (int k = 1; k <= 20; k++) begin
            @(posedge iClk);
            @(negedge iClk);
            if (oMemRdy) begin
                if (n < 2) begin t[n] = k; dq[n] = oMemData; end
                n++;
                if (n == 1) iMemAddr = 32'd1;
                else iMemRead = 1'b0;
            end
        end
        iMemRead = 1'b0;
        checks++;
        if (n != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", n); end
        else begin
            checks++;
            if (t[0] != 4 || t[1] != 9) begin errors++; $display("FAIL b2b_timing got %0d,%0d want 4,9", t[0], t[1]); end
            checks++;
            if (dq[0] !== 32'h100 || dq[1] !== 32'h101) begin
                errors++; $display("FAIL b2b_data got %h,%h want 00000100,00000101", dq[0], dq[1]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat, pulses; logic [31:0] q; int seen = 0;
        run_req(32'd3, 32'h0000_0033, 1'b0, 1'b1, lat, q, pulses);
        @(negedge iClk);
        iMemAddr = 32'd3; iMemData = 32'h1234_5678; iMemWrite = 1'b1;
        @(posedge iClk);   // accepted
        @(posedge iClk);   // in WAIT
        #2 nRst = 1'b0;
        #1;
        checks++;
        if (oMemRdy !== 1'b0 || oMemData !== 32'h0) begin
            errors++; $display("FAIL abort_reset got rdy %0b data %h want 0 0", oMemRdy, oMemData);
        end
        iMemWrite = 1'b0;
        @(negedge iClk);
        nRst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge iClk);
            if (oMemRdy) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_no_rdy got %0d want 0", seen); end
        run_req(32'd3, 32'h0, 1'b1, 1'b0, lat, q, pulses);
        checks++;
        if (q !== 32'h0000_0033) begin errors++; $display("FAIL abort_no_commit got %h want 00000033", q); end
    endtask

    task automatic test_rw_both();
        int lat, pulses; logic [31:0] q;
        run_req(32'd7, 32'h0000_0055, 1'b1, 1'b1, lat, q, pulses);
        checks++;
        if (lat != 4 || q !== 32'h0000_0033) begin
            errors++; $display("FAIL rw_as_write got lat %0d data %h want 4 00000033", lat, q);
        end
        run_req(32'd7, 32'h0, 1'b1, 1'b0, lat, q, pulses);
        checks++;
        if (q !== 32'h0000_0055) begin errors++; $display("FAIL rw_readback got %h want 00000055", q); end
    endtask

    task automatic test_bounds();
        int lat, pulses; logic [31:0] q;
        run_req(32'h0000_0205, 32'h0000_00BB, 1'b0, 1'b1, lat, q, pulses);
        run_req(32'h0000_0200, 32'h0, 1'b1, 1'b0, lat, q, pulses);
        checks++;
        if (lat != 4 || pulses != 1) begin errors++; $display("FAIL oob_timing got lat %0d pulses %0d want 4 1", lat, pulses); end
`ifdef MEM_BOUNDS_EN
        checks++;
        if (q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oob_read got %h want deadbeef", q); end
        checks++;
        if (oMemFault !== 1'b1) begin errors++; $display("FAIL oob_fault got %0b want 1", oMemFault); end
        run_req(32'd5, 32'h0, 1'b1, 1'b0, lat, q, pulses);
        checks++;
        if (q !== 32'h0000_00AA) begin errors++; $display("FAIL oob_write_suppressed got %h want 000000aa", q); end
        checks++;
        if (oMemFault !== 1'b1) begin errors++; $display("FAIL oob_fault_sticky got %0b want 1", oMemFault); end
`else
        checks++;
        if (q !== 32'h0000_0100) begin errors++; $display("FAIL wrap_read got %h want 00000100", q); end
        run_req(32'd5, 32'h0, 1'b1, 1'b0, lat, q, pulses);
        checks++;
        if (q !== 32'h0000_00BB) begin errors++; $display("FAIL wrap_write got %h want 000000bb", q); end
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_abort();
        test_rw_both();
        test_bounds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
